// File: rtl/riscv_mem_unit.sv
// Unified instruction/data memory for the multicycle RISC-V core.
// Request/response handshake with programmable latency and RV32I byte/half/word accesses.
module riscv_mem_unit #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [30:0] DEPTH_W  = 31'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   lane_data;
  logic [31:0]   wr_data;
  logic [15:0]   rd_half;
  logic [3:0]    wr_be;
  logic          access_err;
  logic          do_write;

  assign idx = addr_q[2 +: AW];

  // Lane selection for loads and lane replication/byte enables for stores.
  always_comb begin
    rd_word    = mem[idx];
    rd_half    = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    lane_data  = 32'h0;
    wr_data    = wdata_q;
    wr_be      = 4'b0000;
    access_err = (size_q == 2'b11) ||
                 (size_q == 2'b01 && addr_q[0]) ||
                 (size_q == 2'b10 && addr_q[1:0] != 2'b00) ||
                 ({1'b0, addr_q[31:2]} >= DEPTH_W);
    case (size_q)
      2'b00: begin
        lane_data = {24'h0, rd_word[{addr_q[1:0], 3'b000} +: 8]};
        if (!uns_q) lane_data[31:8] = {24{lane_data[7]}};
        wr_data = {4{wdata_q[7:0]}};
        wr_be   = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        lane_data = {16'h0, rd_half};
        if (!uns_q) lane_data[31:16] = {16{rd_half[15]}};
        wr_data = {2{wdata_q[15:0]}};
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        lane_data = rd_word;
        wr_be     = 4'b1111;
      end
      default: begin
        lane_data = 32'h0;
      end
    endcase
  end

  assign do_write = (state_q == BUSY) && (cnt_q == 4'd0) && we_q && !access_err;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          size_d      = req_size;
          uns_d       = req_unsigned;
          wdata_d     = req_wdata;
          cnt_d       = CNT_INIT;
          req_ready_d = 1'b0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Stores and failed accesses return zero data.
          rsp_valid_d = 1'b1;
          rsp_err_d   = access_err;
          rsp_rdata_d = (access_err || we_q) ? 32'h0 : lane_data;
          state_d     = RESP;
        end
      end
      RESP: begin
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 32'h0;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_riscv_mem_unit.sv
// Scoreboard bench for riscv_mem_unit: one instance at LATENCY 1, one at LATENCY 4.
// Expected responses come from a byte-addressed reference memory.
module tb_riscv_mem_unit;

  localparam int         DEPTH = 1024;
  localparam logic [1:0] SZ_B  = 2'b00;
  localparam logic [1:0] SZ_H  = 2'b01;
  localparam logic [1:0] SZ_W  = 2'b10;
  localparam logic [1:0] SZ_X  = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [31:0] req_addr     [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  riscv_mem_unit #(.DEPTH(DEPTH), .LATENCY(1), .INIT_FILE("")) u_dut_l1 (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  riscv_mem_unit #(.DEPTH(DEPTH), .LATENCY(4), .INIT_FILE("")) u_dut_l4 (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  int          check_count = 0;
  int          pass_count  = 0;
  logic [32:0] exp_q0 [$];
  logic [32:0] exp_q1 [$];
  logic [7:0]  model_mem [int];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic int mkey(input int d, input logic [31:0] a);
    return (d << 16) | int'(a[15:0]);
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Reference model: returns {err, rdata} and commits store bytes.
  task automatic modelAccess(input int d, input logic we, input logic [31:0] addr,
                             input logic [1:0] size, input logic uns,
                             input logic [31:0] wdata, output logic [32:0] exp);
    int          nbytes;
    logic        bad;
    logic [31:0] val;
    nbytes = 1 << size;
    bad = (size == SZ_X) || (size == SZ_H && addr % 2 != 0) ||
          (size == SZ_W && addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
    val = 32'h0;
    if (!bad) begin
      for (int i = 0; i < nbytes; i++) begin
        if (we) model_mem[mkey(d, addr + 32'(i))] = wdata[8*i +: 8];
        else if (model_mem.exists(mkey(d, addr + 32'(i)))) val[8*i +: 8] = model_mem[mkey(d, addr + 32'(i))];
        else val[8*i +: 8] = 8'hxx;
      end
      if (!we && !uns && nbytes == 1) val = {{24{val[7]}}, val[7:0]};
      if (!we && !uns && nbytes == 2) val = {{16{val[15]}}, val[15:0]};
    end
    exp = {bad, (we || bad) ? 32'h0 : val};
  endtask

  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                               input logic [1:0] size, input logic uns,
                               input logic [31:0] wdata, input bit expect_rsp = 1'b1);
    logic [32:0] e;
    int          waited;
    waited = 0;
    @(negedge clk);
    while (!req_ready[d] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready[d]) begin
      checkOutput($sformatf("dut%0d accept timeout", d), 32'(req_ready[d]), 32'h1);
    end else begin
      req_valid[d]    = 1'b1;
      req_we[d]       = we;
      req_addr[d]     = addr;
      req_size[d]     = size;
      req_unsigned[d] = uns;
      req_wdata[d]    = wdata;
      if (expect_rsp) begin
        modelAccess(d, we, addr, size, uns, wdata, e);
        if (d == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid[d]    = 1'b0;
      req_we[d]       = 1'($urandom);
      req_addr[d]     = $urandom;
      req_size[d]     = 2'($urandom);
      req_unsigned[d] = 1'($urandom);
      req_wdata[d]    = $urandom;
    end
  endtask

  task automatic waitDrain(input int d);
    int n;
    n = 0;
    while ((qsize(d) != 0 || !req_ready[d]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (qsize(d) != 0) checkOutput($sformatf("dut%0d drain timeout", d), 32'(qsize(d)), 32'h0);
  endtask

  logic        prev_valid0 = 1'b0;
  logic        prev_valid1 = 1'b0;
  logic [32:0] e0, e1;

  always @(negedge clk) begin
    if (rst_n[0] === 1'b1 && rsp_valid[0] === 1'b1) begin
      checkOutput("dut0 rsp_valid pulse width", 32'(prev_valid0), 32'h0);
      if (exp_q0.size() == 0) begin
        checkOutput("dut0 unexpected rsp_valid", 32'(rsp_valid[0]), 32'h0);
      end else begin
        e0 = exp_q0.pop_front();
        checkOutput("dut0 rsp_rdata", rsp_rdata[0], e0[31:0]);
        checkOutput("dut0 rsp_err", 32'(rsp_err[0]), 32'(e0[32]));
      end
    end
    prev_valid0 = rsp_valid[0];
  end

  always @(negedge clk) begin
    if (rst_n[1] === 1'b1 && rsp_valid[1] === 1'b1) begin
      checkOutput("dut1 rsp_valid pulse width", 32'(prev_valid1), 32'h0);
      if (exp_q1.size() == 0) begin
        checkOutput("dut1 unexpected rsp_valid", 32'(rsp_valid[1]), 32'h0);
      end else begin
        e1 = exp_q1.pop_front();
        checkOutput("dut1 rsp_rdata", rsp_rdata[1], e1[31:0]);
        checkOutput("dut1 rsp_err", 32'(rsp_err[1]), 32'(e1[32]));
      end
    end
    prev_valid1 = rsp_valid[1];
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global timeout: observed no finish, expected finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [32:0] e;
    logic [31:0] a;
    logic [1:0]  sz;
    int          last_acc;
    int          acc_count;

    for (int d = 0; d < 2; d++) begin
      rst_n[d]        = 1'b0;
      req_valid[d]    = 1'b0;
      req_we[d]       = 1'b0;
      req_addr[d]     = 32'h0;
      req_size[d]     = 2'b00;
      req_unsigned[d] = 1'b0;
      req_wdata[d]    = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d reset req_ready", d), 32'(req_ready[d]), 32'h1);
      checkOutput($sformatf("dut%0d reset rsp_valid", d), 32'(rsp_valid[d]), 32'h0);
      checkOutput($sformatf("dut%0d reset rsp_rdata", d), rsp_rdata[d], 32'h0);
      checkOutput($sformatf("dut%0d reset rsp_err", d), 32'(rsp_err[d]), 32'h0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Word fetch timing at LATENCY 1
    applyStimulus(0, 1'b1, 32'h10, SZ_W, 1'b0, 32'h0000_0013);
    waitDrain(0);
    applyStimulus(0, 1'b0, 32'h10, SZ_W, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("fetch cycle1 rsp_valid", 32'(rsp_valid[0]), 32'h0);
    @(negedge clk);
    checkOutput("fetch cycle2 rsp_valid", 32'(rsp_valid[0]), 32'h1);
    checkOutput("fetch cycle2 req_ready", 32'(req_ready[0]), 32'h0);
    checkOutput("fetch cycle2 rsp_rdata", rsp_rdata[0], 32'h0000_0013);
    @(negedge clk);
    checkOutput("fetch cycle3 req_ready", 32'(req_ready[0]), 32'h1);
    checkOutput("fetch cycle3 rsp_valid", 32'(rsp_valid[0]), 32'h0);

    // Sign/zero extension
    applyStimulus(0, 1'b1, 32'h20, SZ_W, 1'b0, 32'h8081_F0FF);
    applyStimulus(0, 1'b0, 32'h20, SZ_B, 1'b0, 32'h0);
    applyStimulus(0, 1'b0, 32'h21, SZ_B, 1'b1, 32'h0);
    applyStimulus(0, 1'b0, 32'h22, SZ_H, 1'b0, 32'h0);
    applyStimulus(0, 1'b0, 32'h22, SZ_H, 1'b1, 32'h0);
    applyStimulus(0, 1'b0, 32'h23, SZ_B, 1'b0, 32'h0);
    applyStimulus(0, 1'b0, 32'h20, SZ_H, 1'b0, 32'h0);

    // Partial stores and error cases
    applyStimulus(0, 1'b1, 32'h40, SZ_W, 1'b0, 32'h1122_3344);
    applyStimulus(0, 1'b1, 32'h41, SZ_B, 1'b0, 32'h0000_00AA);
    applyStimulus(0, 1'b1, 32'h42, SZ_H, 1'b0, 32'h0000_BEEF);
    applyStimulus(0, 1'b0, 32'h40, SZ_W, 1'b0, 32'h0);
    applyStimulus(0, 1'b0, 32'h42, SZ_W, 1'b0, 32'h0);
    applyStimulus(0, 1'b1, 32'h43, SZ_H, 1'b0, 32'h1234_5678);
    applyStimulus(0, 1'b0, 32'h40, SZ_X, 1'b0, 32'h0);
    applyStimulus(0, 1'b0, 32'h1000, SZ_W, 1'b0, 32'h0);
    applyStimulus(0, 1'b1, 32'h41, SZ_W, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(0, 1'b0, 32'h40, SZ_W, 1'b0, 32'h0);
    applyStimulus(0, 1'b1, 32'hFFC, SZ_W, 1'b0, 32'hCAFE_F00D);
    applyStimulus(0, 1'b0, 32'hFFF, SZ_B, 1'b1, 32'h0);
    applyStimulus(0, 1'b0, 32'hFFC, SZ_W, 1'b0, 32'h0);
    waitDrain(0);
    checkOutput("explicit lw 0x40 after partial stores", 32'({model_mem[mkey(0, 32'h43)], model_mem[mkey(0, 32'h42)],
                model_mem[mkey(0, 32'h41)], model_mem[mkey(0, 32'h40)]}), 32'hBEEF_AA44);

    // Held request at LATENCY 4: one accept every 6 cycles
    for (int i = 0; i < 8; i++) applyStimulus(1, 1'b1, 32'h100 + 32'(4 * i), SZ_W, 1'b0, $urandom);
    waitDrain(1);
    last_acc  = -1;
    acc_count = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      sz = 2'($urandom_range(0, 2));
      a  = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if (sz == SZ_H) a = a + 32'(2 * $urandom_range(0, 1));
      if (sz == SZ_B) a = a + 32'($urandom_range(0, 3));
      req_valid[1]    = 1'b1;
      req_we[1]       = 1'b0;
      req_addr[1]     = a;
      req_size[1]     = sz;
      req_unsigned[1] = 1'($urandom);
      if (req_ready[1]) begin
        modelAccess(1, 1'b0, a, sz, req_unsigned[1], 32'h0, e);
        exp_q1.push_back(e);
        if (last_acc >= 0) checkOutput("hold accept spacing", 32'(c - last_acc), 32'd6);
        last_acc = c;
        acc_count++;
      end
    end
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    waitDrain(1);
    checkOutput("hold accept count", 32'(acc_count), 32'd7);

    // Reset while BUSY aborts a store
    applyStimulus(1, 1'b1, 32'h80, SZ_W, 1'b0, 32'h0);
    waitDrain(1);
    applyStimulus(1, 1'b1, 32'h80, SZ_W, 1'b0, 32'h5555_5555, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    checkOutput("abort req_ready", 32'(req_ready[1]), 32'h1);
    checkOutput("abort rsp_valid", 32'(rsp_valid[1]), 32'h0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(1, 1'b0, 32'h80, SZ_W, 1'b0, 32'h0);
    waitDrain(1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
